// File: rtl/cc_rst_ctrl.sv
// cc_rst_ctrl: soft-reset sequencer for one core (block AXI, drain,
// hold core in reset, release with a freshly latched boot address).
// Optional: define CC_RST_CTRL_TIMEOUT_EN to bound DRAIN by DRAIN_TIMEOUT.
// Ports:
//   clk_i, rst_ni          clock, sync active-low reset
//   cfg_rst_i, cfg_boot_i  syscfg soft-reset request (low) / boot addr
//   aw/b/ar/r_last_fire_i  core master port handshakes
//   axi_block_o            gate AW/AR valid toward interconnect
//   core_rst_no            core soft reset, active-low
//   core_boot_o            core boot address
//   busy_o, done_o         not-RUN flag, release pulse
//   timeout_o              sticky drain timeout flag
module cc_rst_ctrl #(
  parameter int          RST_CYCLES    = 16,
  parameter int          OUTSTD_W      = 4,
  parameter int          DRAIN_TIMEOUT = 1024,
  parameter logic [31:0] BOOT_DEFAULT  = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cfg_rst_i,
  input  logic [31:0] cfg_boot_i,
  input  logic        aw_fire_i,
  input  logic        b_fire_i,
  input  logic        ar_fire_i,
  input  logic        r_last_fire_i,
  output logic        axi_block_o,
  output logic        core_rst_no,
  output logic [31:0] core_boot_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o
);

  if (RST_CYCLES < 1 || RST_CYCLES > 255 ||
      DRAIN_TIMEOUT < 1) begin : g_param_chk
    $error("cc_rst_ctrl: illegal parameter");
  end

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_MAX = 8'(RST_CYCLES - 1);

  state_t              state;
  logic [OUTSTD_W-1:0] wr_cnt;
  logic [OUTSTD_W-1:0] rd_cnt;
  logic [7:0]          hold_cnt;
  logic                cnt_zero;
  logic                drain_exit;

  function automatic logic [OUTSTD_W-1:0] cnt_upd(
    input logic [OUTSTD_W-1:0] c,
    input logic                inc,
    input logic                dec
  );
    logic [OUTSTD_W-1:0] r;
    r = c;
    if (inc && !dec && c != '1)
      r = c + OUTSTD_W'(1);
    else if (dec && !inc && c != '0)
      r = c - OUTSTD_W'(1);
    return r;
  endfunction

  assign cnt_zero = (wr_cnt == '0) && (rd_cnt == '0);

`ifdef CC_RST_CTRL_TIMEOUT_EN
  localparam int DCW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [DCW-1:0] DRAIN_MAX = DCW'(DRAIN_TIMEOUT - 1);

  logic [DCW-1:0] drain_cnt;
  logic           drain_tmo;

  assign drain_tmo  = drain_cnt == DRAIN_MAX;
  assign drain_exit = cnt_zero || drain_tmo;
`else
  assign drain_exit = cnt_zero;
  assign timeout_o  = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= RUN;
      core_rst_no <= 1'b1;
      axi_block_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      core_boot_o <= BOOT_DEFAULT;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      hold_cnt    <= '0;
`ifdef CC_RST_CTRL_TIMEOUT_EN
      drain_cnt   <= '0;
      timeout_o   <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      if (state != HOLD) begin
        wr_cnt <= cnt_upd(wr_cnt, aw_fire_i, b_fire_i);
        rd_cnt <= cnt_upd(rd_cnt, ar_fire_i, r_last_fire_i);
      end
      unique case (state)
        RUN: begin
          if (!cfg_rst_i) begin
            state       <= DRAIN;
            axi_block_o <= 1'b1;
            busy_o      <= 1'b1;
`ifdef CC_RST_CTRL_TIMEOUT_EN
            drain_cnt   <= '0;
`endif
          end
        end
        DRAIN: begin
`ifdef CC_RST_CTRL_TIMEOUT_EN
          drain_cnt <= drain_cnt + DCW'(1);
          if (drain_tmo && !cnt_zero)
            timeout_o <= 1'b1;
`endif
          // reset is committed here: cfg_rst_i is not looked at
          if (drain_exit) begin
            state       <= HOLD;
            core_rst_no <= 1'b0;
            hold_cnt    <= '0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
          end
        end
        HOLD: begin
          if (hold_cnt != HOLD_MAX)
            hold_cnt <= hold_cnt + 8'd1;
          if (hold_cnt == HOLD_MAX && cfg_rst_i) begin
            state       <= RUN;
            core_rst_no <= 1'b1;
            axi_block_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            core_boot_o <= cfg_boot_i;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_cc_rst_ctrl.sv
// tb_cc_rst_ctrl: directed + random stimulus for cc_rst_ctrl,
// checked every cycle against a behavioural reference model.
module tb_cc_rst_ctrl;

  localparam int          RST_CYCLES    = 16;
  localparam int          OUTSTD_W      = 4;
  localparam int          DRAIN_TIMEOUT = 1024;
  localparam logic [31:0] BOOT_DEFAULT  = 32'h8000_0000;
  localparam int          CNT_MAX       = (1 << OUTSTD_W) - 1;

`ifdef CC_RST_CTRL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int PH_RUN   = 0;
  localparam int PH_DRAIN = 1;
  localparam int PH_HOLD  = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cfg_rst_i = 1'b1;
  logic [31:0] cfg_boot_i = '0;
  logic        aw_fire_i = 1'b0;
  logic        b_fire_i = 1'b0;
  logic        ar_fire_i = 1'b0;
  logic        r_last_fire_i = 1'b0;
  logic        axi_block_o;
  logic        core_rst_no;
  logic [31:0] core_boot_o;
  logic        busy_o;
  logic        done_o;
  logic        timeout_o;

  cc_rst_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .OUTSTD_W     (OUTSTD_W),
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT),
    .BOOT_DEFAULT (BOOT_DEFAULT)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cfg_rst_i    (cfg_rst_i),
    .cfg_boot_i   (cfg_boot_i),
    .aw_fire_i    (aw_fire_i),
    .b_fire_i     (b_fire_i),
    .ar_fire_i    (ar_fire_i),
    .r_last_fire_i(r_last_fire_i),
    .axi_block_o  (axi_block_o),
    .core_rst_no  (core_rst_no),
    .core_boot_o  (core_boot_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: phase, outstanding counts, ages in cycles
  int          m_ph = PH_RUN;
  int          m_wr = 0;
  int          m_rd = 0;
  int          m_age = 0;
  int          m_dage = 0;
  bit          m_done = 1'b0;
  bit          m_tmo = 1'b0;
  logic [31:0] m_boot = BOOT_DEFAULT;

  int          low_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] boot_v = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    if (v < 0) return 0;
    if (v > CNT_MAX) return CNT_MAX;
    return v;
  endfunction

  task automatic model_step();
    int nw;
    int nr;
    if (!rst_ni) begin
      m_ph = PH_RUN; m_wr = 0; m_rd = 0; m_age = 0; m_dage = 0;
      m_done = 1'b0; m_tmo = 1'b0; m_boot = BOOT_DEFAULT;
      return;
    end
    m_done = 1'b0;
    nw = sat(m_wr + int'(aw_fire_i) - int'(b_fire_i));
    nr = sat(m_rd + int'(ar_fire_i) - int'(r_last_fire_i));
    case (m_ph)
      PH_RUN: begin
        m_wr = nw; m_rd = nr;
        if (!cfg_rst_i) begin m_ph = PH_DRAIN; m_dage = 0; end
      end
      PH_DRAIN: begin
        if (m_wr == 0 && m_rd == 0) begin
          m_ph = PH_HOLD; m_wr = 0; m_rd = 0; m_age = 0;
        end else if (TMO_EN && m_dage >= DRAIN_TIMEOUT - 1) begin
          m_ph = PH_HOLD; m_wr = 0; m_rd = 0; m_age = 0;
          m_tmo = 1'b1;
        end else begin
          m_wr = nw; m_rd = nr; m_dage++;
        end
      end
      default: begin
        if (cfg_rst_i && m_age >= RST_CYCLES - 1) begin
          m_ph = PH_RUN; m_done = 1'b1; m_boot = cfg_boot_i;
        end else begin
          m_age++;
        end
      end
    endcase
  endtask

  task automatic check_all();
    chk("core_rst_no", 32'(core_rst_no), 32'(m_ph != PH_HOLD));
    chk("axi_block", 32'(axi_block_o), 32'(m_ph != PH_RUN));
    chk("busy", 32'(busy_o), 32'(m_ph != PH_RUN));
    chk("done", 32'(done_o), 32'(m_done));
    chk("boot", core_boot_o, m_boot);
    chk("timeout", 32'(timeout_o), 32'(m_tmo));
    chk("wr_cnt", 32'(dut.wr_cnt), 32'(m_wr));
    chk("rd_cnt", 32'(dut.rd_cnt), 32'(m_rd));
  endtask

  task automatic cyc(input logic rn, input logic cr, input logic aw,
                     input logic b, input logic ar, input logic rl);
    @(negedge clk_i);
    rst_ni = rn; cfg_rst_i = cr; cfg_boot_i = boot_v;
    aw_fire_i = aw; b_fire_i = b; ar_fire_i = ar; r_last_fire_i = rl;
    @(posedge clk_i);
    model_step();
    #1;
    check_all();
    if (!core_rst_no) low_cnt++;
    if (done_o) done_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_until_done();
    int k;
    k = 0;
    do begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      k++;
    end while (!done_o && k < 400);
    if (!done_o) chk("done_wait", 32'(done_o), 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic rn, cr, aw, ar;

    // reset state
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // idle reset request at cycle 10
    boot_v = 32'h0000_1000;
    idle(7);
    low_cnt = 0; done_cnt = 0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_block", 32'(axi_block_o), 32'd1);
    run_until_done();
    chk("idle_low_len", 32'(low_cnt), 32'(RST_CYCLES));
    chk("idle_boot", core_boot_o, 32'h0000_1000);
    idle(2);
    chk("idle_done_once", 32'(done_cnt), 32'd1);

    // simultaneous events and underflow
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sim_wr2", 32'(dut.wr_cnt), 32'd2);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("underflow_wr0", 32'(dut.wr_cnt), 32'd0);

    // drain wait: 3 AW, 2 AR outstanding
    boot_v = 32'h0000_2000;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    chk("drain_wait_rst", 32'(core_rst_no), 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("drain_last_rst", 32'(core_rst_no), 32'd1);
    idle(1);
    chk("drain_fall", 32'(core_rst_no), 32'd0);
    run_until_done();
    chk("drain_boot", core_boot_o, 32'h0000_2000);

    // extended hold: request held low for 40 cycles
    boot_v = 32'hCAFE_0000;
    low_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ext_no_done", 32'(done_cnt), 32'd0);
    chk("ext_still_low", 32'(core_rst_no), 32'd0);
    run_until_done();
    chk("ext_low_len", 32'(low_cnt), 32'd39);
    chk("ext_boot", core_boot_o, 32'hCAFE_0000);

    // reset in HOLD, fifth cycle
    boot_v = 32'h1234_5678;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_in_hold", 32'(core_rst_no), 32'd0);
    done_cnt = 0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_no", 32'(core_rst_no), 32'd1);
    chk("mid_block", 32'(axi_block_o), 32'd0);
    chk("mid_boot", core_boot_o, BOOT_DEFAULT);
    idle(RST_CYCLES + 2);
    chk("mid_no_done", 32'(done_cnt), 32'd0);

    // stuck write in DRAIN
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CC_RST_CTRL_TIMEOUT_EN
    n = 0;
    while (core_rst_no && n < DRAIN_TIMEOUT + 50) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("tmo_drain_len", 32'(n), 32'(DRAIN_TIMEOUT));
    chk("tmo_set", 32'(timeout_o), 32'd1);
    run_until_done();
    idle(3);
    chk("tmo_sticky", 32'(timeout_o), 32'd1);
`else
    idle(60);
    chk("stuck_rst_no", 32'(core_rst_no), 32'd1);
    chk("stuck_no_tmo", 32'(timeout_o), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_until_done();
`endif

    // randomized traffic, requests and resets
    for (int i = 0; i < 3000; i++) begin
      boot_v = $urandom;
      rn = ($urandom_range(0, 199) != 0);
      cr = ($urandom_range(0, 24) != 0);
      aw = ($urandom_range(0, 2) == 0);
      ar = ($urandom_range(0, 2) == 0);
      if (m_ph == PH_DRAIN) begin aw = 1'b0; ar = 1'b0; end
      cyc(rn, cr, aw, ($urandom_range(0, 2) == 0),
          ar, ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
